meter_credit_ctrl: RTL and testbench

// Payment-side front end of the parking meter: turns debounced coin presses into purchased time
// and drives the countdown timer's load/run interface (time_in, enable). Accumulates credit,

---
 rtl/meter_pkg.sv | 29 ++
 rtl/sec_tick_gen.sv | 26 ++
 rtl/meter_credit_ctrl.sv | 179 +++++++++++++++++
 tb/tb_meter_credit_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/meter_pkg.sv
// Shared parking-meter types: controller states, default coin/limit values and the
// saturating adder used for credit and top-up arithmetic.
package meter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCUM   = 3'd1,
        RUN     = 3'd2,
        TOPUP   = 3'd3,
        EXPIRED = 3'd4
    } state_t;

    localparam int TIME_W_DEF       = 8;
    localparam int MAX_TIME_DEF     = 99;
    localparam int COIN_A_VALUE_DEF = 5;
    localparam int COIN_B_VALUE_DEF = 25;

    // Wide enough for any time value the meter uses; callers narrow the result.
    localparam int SAT_W = 16;

    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] x,
                                                 input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] max_v);
        logic [SAT_W:0] sum;
        sum = {1'b0, x} + {1'b0, v};
        return (sum > {1'b0, max_v}) ? max_v : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-cycle tick every CLOCK_FREQ clocks; a synchronous clear restarts the second.
module sec_tick_gen #(
    parameter int CLOCK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCK_FREQ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !clr && (cnt_q == LAST);
        cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/meter_credit_ctrl.sv
// Parking-meter payment front end: coin edges become credit, credit loads the countdown
// timer, running time can be topped up, and expiry is flagged.
module meter_credit_ctrl
    import meter_pkg::*;
#(
    parameter int CLOCK_FREQ     = 50_000_000,
    parameter int TIME_W         = TIME_W_DEF,
    parameter int MAX_TIME       = MAX_TIME_DEF,
    parameter int COIN_A_VALUE   = COIN_A_VALUE_DEF,
    parameter int COIN_B_VALUE   = COIN_B_VALUE_DEF,
    parameter int IDLE_TIMEOUT_S = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              coin_a,
    input  logic              coin_b,
    input  logic              start,
    input  logic              cancel,
    input  logic [TIME_W-1:0] time_remaining,
    output logic [TIME_W-1:0] time_in,
    output logic              enable,
    output logic [TIME_W-1:0] credit,
    output logic              expired,
    output logic              coin_reject,
    output logic [2:0]        state_out
);

    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);
    localparam logic [TIME_W-1:0] VAL_A = TIME_W'(COIN_A_VALUE);
    localparam logic [TIME_W-1:0] VAL_B = TIME_W'(COIN_B_VALUE);
    localparam int SEC_W = (IDLE_TIMEOUT_S > 1) ? $clog2(IDLE_TIMEOUT_S + 1) : 1;
    localparam logic [SEC_W-1:0] TO_LAST = SEC_W'(IDLE_TIMEOUT_S - 1);

    // Previous input levels and the registered edge events derived from them.
    logic              coin_a_q, coin_b_q, start_q, cancel_q;
    logic [TIME_W:0]   v_q, v_d;
    logic              start_ev_q, start_ev_d, cancel_ev_q, cancel_ev_d;

    state_t            state_q, state_d;
    logic [TIME_W-1:0] credit_q, credit_d, topup_q, topup_d, time_in_q, time_in_d;
    logic              pend_q, pend_d, enable_q, enable_d, expired_q, expired_d;
    logic              coin_reject_q, coin_reject_d;
    logic [SEC_W-1:0]  sec_cnt_q, sec_cnt_d;

    logic              coin_in, tick, tmr_clr, timeout;
    logic [TIME_W-1:0] sat_base, sum;

    sec_tick_gen #(.CLOCK_FREQ(CLOCK_FREQ)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .tick    (tick)
    );

    always_comb begin
        v_d         = ((coin_a && !coin_a_q) ? {1'b0, VAL_A} : '0)
                    + ((coin_b && !coin_b_q) ? {1'b0, VAL_B} : '0);
        start_ev_d  = start && !start_q;
        cancel_ev_d = cancel && !cancel_q;

        coin_in   = (v_q != '0);
        tmr_clr   = (state_q != ACCUM) || coin_in;
        timeout   = tick && (sec_cnt_q == TO_LAST);
        sec_cnt_d = tmr_clr ? '0 : ((tick && !timeout) ? sec_cnt_q + 1'b1 : sec_cnt_q);

        // sat_base is whatever the incoming coin value is added to in the current state.
        case (state_q)
            ACCUM:   sat_base = credit_q;
            RUN:     sat_base = time_remaining;
            TOPUP:   sat_base = topup_q;
            default: sat_base = '0;
        endcase
        sum           = TIME_W'(sat_add(SAT_W'(sat_base), SAT_W'(v_q), SAT_W'(MAX_T)));
        coin_reject_d = coin_in && (sat_base == MAX_T);

        state_d  = state_q;
        credit_d = credit_q;
        topup_d  = topup_q;
        pend_d   = pend_q;
        case (state_q)
            IDLE: if (coin_in) begin
                state_d  = ACCUM;
                credit_d = sum;
            end
            ACCUM: begin
                if (cancel_ev_q) begin
                    state_d  = IDLE;
                    credit_d = '0;
                    pend_d   = 1'b0;
                end else begin
                    if (start_ev_q || timeout) pend_d = 1'b1;
                    // Only hand over once the timer is known to hold the unchanged credit.
                    if (coin_in) begin
                        credit_d = sum;
                    end else if (pend_q && (time_remaining == credit_q)) begin
                        state_d  = RUN;
                        credit_d = '0;
                        pend_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                if (coin_in) begin
                    state_d = TOPUP;
                    topup_d = sum;
                end else if (time_remaining == '0) begin
                    state_d = EXPIRED;
                end
            end
            TOPUP: begin
                if (coin_in) topup_d = sum;
                else         state_d = RUN;
            end
            EXPIRED: begin
                if (coin_in) begin
                    state_d  = ACCUM;
                    credit_d = sum;
                end else if (cancel_ev_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        enable_d  = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
        case (state_d)
            ACCUM:   time_in_d = credit_d;
            TOPUP:   time_in_d = topup_d;
            default: time_in_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coin_a_q      <= 1'b0;
            coin_b_q      <= 1'b0;
            start_q       <= 1'b0;
            cancel_q      <= 1'b0;
            v_q           <= '0;
            start_ev_q    <= 1'b0;
            cancel_ev_q   <= 1'b0;
            state_q       <= IDLE;
            credit_q      <= '0;
            topup_q       <= '0;
            pend_q        <= 1'b0;
            sec_cnt_q     <= '0;
            time_in_q     <= '0;
            enable_q      <= 1'b0;
            expired_q     <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            coin_a_q      <= coin_a;
            coin_b_q      <= coin_b;
            start_q       <= start;
            cancel_q      <= cancel;
            v_q           <= v_d;
            start_ev_q    <= start_ev_d;
            cancel_ev_q   <= cancel_ev_d;
            state_q       <= state_d;
            credit_q      <= credit_d;
            topup_q       <= topup_d;
            pend_q        <= pend_d;
            sec_cnt_q     <= sec_cnt_d;
            time_in_q     <= time_in_d;
            enable_q      <= enable_d;
            expired_q     <= expired_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign time_in     = time_in_q;
    assign enable      = enable_q;
    assign credit      = credit_q;
    assign expired     = expired_q;
    assign coin_reject = coin_reject_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_meter_credit_ctrl.sv
// Directed bench for meter_credit_ctrl with a behavioural countdown timer as load partner.
module tb_meter_credit_ctrl;
    import meter_pkg::*;

    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          coin_a = 1'b0, coin_b = 1'b0, start = 1'b0, cancel = 1'b0;
    logic [TW-1:0] time_remaining, time_in, credit;
    logic          enable, expired, coin_reject;
    logic [2:0]    state_out;
    logic [3:0]    sub_q;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    meter_credit_ctrl #(
        .CLOCK_FREQ(10), .TIME_W(TW), .MAX_TIME(99),
        .COIN_A_VALUE(5), .COIN_B_VALUE(25), .IDLE_TIMEOUT_S(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .coin_a(coin_a), .coin_b(coin_b),
        .start(start), .cancel(cancel), .time_remaining(time_remaining),
        .time_in(time_in), .enable(enable), .credit(credit), .expired(expired),
        .coin_reject(coin_reject), .state_out(state_out)
    );

    // Countdown timer: loads while enable=0, otherwise drops one second per 10 clocks.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            time_remaining <= '0;
            sub_q          <= '0;
        end else if (!enable) begin
            time_remaining <= time_in;
            sub_q          <= '0;
        end else if (time_remaining != '0) begin
            if (sub_q == 4'd9) begin
                sub_q          <= '0;
                time_remaining <= time_remaining - 8'd1;
            end else begin
                sub_q <= sub_q + 4'd1;
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Raise the chosen inputs for one cycle; returns two edges later, when outputs reflect it.
    task automatic pulse(input logic a, input logic b, input logic s, input logic c);
        @(negedge clk);
        coin_a = a; coin_b = b; start = s; cancel = c;
        @(negedge clk);
        coin_a = 1'b0; coin_b = 1'b0; start = 1'b0; cancel = 1'b0;
        @(negedge clk);
    endtask

    int n;
    int exp_credit [4] = '{25, 50, 75, 99};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", int'(state_out), int'(IDLE));
        chk("rst_enable", int'(enable), 0);
        chk("rst_time_in", int'(time_in), 0);
        chk("rst_credit", int'(credit), 0);
        chk("rst_expired", int'(expired), 0);
        chk("rst_reject", int'(coin_reject), 0);
        reset_n = 1'b1;

        // Two coin_a then start: run from 10 down to expiry.
        pulse(1, 0, 0, 0);
        chk("a1_credit", int'(credit), 5);
        chk("a1_state", int'(state_out), int'(ACCUM));
        chk("a1_time_in", int'(time_in), 5);
        pulse(1, 0, 0, 0);
        chk("a2_credit", int'(credit), 10);
        pulse(0, 0, 1, 0);
        for (n = 0; n < 20 && !enable; n++) @(negedge clk);
        chk("start_wait", int'(n < 20), 1);
        chk("run_time", int'(time_remaining), 10);
        chk("run_credit", int'(credit), 0);
        for (n = 0; n < 200 && !expired; n++) @(negedge clk);
        chk("expire_wait", int'(n < 200), 1);
        chk("exp_state", int'(state_out), int'(EXPIRED));
        chk("exp_time", int'(time_remaining), 0);
        chk("exp_enable", int'(enable), 0);

        // Cancel from EXPIRED, then saturate credit with coin_b.
        pulse(0, 0, 0, 1);
        chk("exp_cancel_state", int'(state_out), int'(IDLE));
        for (int i = 0; i < 4; i++) begin
            pulse(0, 1, 0, 0);
            chk("b_credit", int'(credit), exp_credit[i]);
        end
        chk("b4_no_reject", int'(coin_reject), 0);
        pulse(0, 1, 0, 0);
        chk("b5_credit", int'(credit), 99);
        chk("b5_reject", int'(coin_reject), 1);
        @(negedge clk);
        chk("b5_reject_pulse", int'(coin_reject), 0);
        pulse(0, 0, 0, 1);
        chk("cancel_state", int'(state_out), int'(IDLE));
        chk("cancel_credit", int'(credit), 0);

        // Both coins in one cycle, then auto-start after the idle timeout.
        pulse(1, 1, 0, 0);
        chk("ab_credit", int'(credit), 30);
        for (n = 0; n < 80 && !enable; n++) @(negedge clk);
        chk("auto_start_window", int'(n >= 49 && n <= 55), 1);
        chk("auto_run_time", int'(time_remaining), 30);
        chk("auto_run_state", int'(state_out), int'(RUN));

        // Top-up during RUN at 30.
        pulse(1, 0, 0, 0);
        chk("topup_state", int'(state_out), int'(TOPUP));
        chk("topup_enable", int'(enable), 0);
        chk("topup_time_in", int'(time_in), 35);
        @(negedge clk);
        chk("topup_run_state", int'(state_out), int'(RUN));
        chk("topup_run_enable", int'(enable), 1);
        chk("topup_run_time", int'(time_remaining), 35);

        pulse(0, 0, 0, 1);
        chk("run_cancel_ignored", int'(state_out), int'(RUN));
        chk("run_cancel_enable", int'(enable), 1);

        // Asynchronous reset while running at 20.
        for (n = 0; n < 250 && time_remaining != 8'd20; n++) @(negedge clk);
        chk("reach20_wait", int'(n < 250), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_state", int'(state_out), int'(IDLE));
        chk("mid_rst_enable", int'(enable), 0);
        chk("mid_rst_time_in", int'(time_in), 0);
        chk("mid_rst_credit", int'(credit), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Cancel beats a coin in the same cycle.
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        chk("c_credit10", int'(credit), 10);
        pulse(1, 0, 0, 1);
        chk("cancel_coin_state", int'(state_out), int'(IDLE));
        chk("cancel_coin_credit", int'(credit), 0);

        // Coin while EXPIRED starts a new purchase.
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        for (n = 0; n < 150 && !expired; n++) @(negedge clk);
        chk("expire2_wait", int'(n < 150), 1);
        pulse(1, 0, 0, 0);
        chk("exp_coin_state", int'(state_out), int'(ACCUM));
        chk("exp_coin_credit", int'(credit), 5);
        chk("exp_coin_expired", int'(expired), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
